// File: rtl/stage_ex_pkg.sv
// Shared types and codes for the EX stage: control word layout, ALU op/funct codes,
// internal ALU controls and the ID/EX and EX/MEM register payloads.
package stage_ex_pkg;

  localparam int unsigned W      = 32;
  localparam int unsigned RW     = 5;
  localparam int unsigned CTRL_W = 8;
  localparam int unsigned FUNCT_W = 6;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FUNCT_NOR = 6'b100111;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_CTL_ADD,
    ALU_CTL_SUB,
    ALU_CTL_AND,
    ALU_CTL_OR,
    ALU_CTL_NOR,
    ALU_CTL_SLT,
    ALU_CTL_NONE
  } alu_ctl_e;

  // Bit order matches the 8-bit control word produced by ID.
  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
  } ctrl_t;

  typedef struct packed {
    logic          valid;
    logic [W-1:0]  pc4;
    logic [W-1:0]  rd1;
    logic [W-1:0]  rd2;
    logic [W-1:0]  imm;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] rd;
    ctrl_t         ctrl;
  } id_ex_t;

  typedef struct packed {
    logic          valid;
    logic [W-1:0]  alu_result;
    logic [W-1:0]  store_data;
    logic [RW-1:0] write_reg;
    logic [W-1:0]  branch_pc;
    logic          branch_taken;
    logic          mem_read;
    logic          mem_write;
    logic          reg_write;
  } ex_mem_t;

  // ALU_CTL_NONE marks an unsupported op; the stage suppresses its register write.
  function automatic alu_ctl_e alu_decode(input logic [1:0] alu_op,
                                          input logic [FUNCT_W-1:0] funct);
    alu_ctl_e ctl;
    ctl = ALU_CTL_NONE;
    case (alu_op)
      ALU_OP_ADD: ctl = ALU_CTL_ADD;
      ALU_OP_SUB: ctl = ALU_CTL_SUB;
      ALU_OP_FUNCT: begin
        case (funct)
          FUNCT_ADD: ctl = ALU_CTL_ADD;
          FUNCT_SUB: ctl = ALU_CTL_SUB;
          FUNCT_AND: ctl = ALU_CTL_AND;
          FUNCT_OR:  ctl = ALU_CTL_OR;
          FUNCT_NOR: ctl = ALU_CTL_NOR;
          FUNCT_SLT: ctl = ALU_CTL_SLT;
          default:   ctl = ALU_CTL_NONE;
        endcase
      end
      default: ctl = ALU_CTL_NONE;
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/stage_ex_if.sv
// ID -> EX -> MEM bus: ID payload, pipeline control, MEM/WB forward source and EX/MEM results.
interface stage_ex_if;
  import stage_ex_pkg::*;

  logic              id_valid;
  logic [W-1:0]      id_pc4;
  logic [W-1:0]      id_rd1;
  logic [W-1:0]      id_rd2;
  logic [W-1:0]      id_imm;
  logic [RW-1:0]     id_rs;
  logic [RW-1:0]     id_rt;
  logic [RW-1:0]     id_rd;
  logic [CTRL_W-1:0] id_ctrl;

  logic              ex_stall;
  logic              ex_flush;

  logic              wb_reg_write;
  logic [RW-1:0]     wb_write_reg;
  logic [W-1:0]      wb_data;

  logic              ex_valid;
  logic [W-1:0]      ex_alu_result;
  logic [W-1:0]      ex_store_data;
  logic [RW-1:0]     ex_write_reg;
  logic [W-1:0]      ex_branch_pc;
  logic              ex_branch_taken;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_reg_write;

  modport master (
    output id_valid, id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, id_ctrl,
    output ex_stall, ex_flush, wb_reg_write, wb_write_reg, wb_data,
    input  ex_valid, ex_alu_result, ex_store_data, ex_write_reg, ex_branch_pc,
    input  ex_branch_taken, ex_mem_read, ex_mem_write, ex_reg_write
  );

  modport slave (
    input  id_valid, id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, id_ctrl,
    input  ex_stall, ex_flush, wb_reg_write, wb_write_reg, wb_data,
    output ex_valid, ex_alu_result, ex_store_data, ex_write_reg, ex_branch_pc,
    output ex_branch_taken, ex_mem_read, ex_mem_write, ex_reg_write
  );

endinterface

// File: rtl/stage_ex_alu.sv
// Combinational ALU for the EX stage; arithmetic wraps, slt is signed.
module ex_alu
  import stage_ex_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  alu_ctl_e     alu_ctl,
  output logic [W-1:0] result,
  output logic         zero
);

  always_comb begin
    result = '0;
    case (alu_ctl)
      ALU_CTL_ADD: result = a + b;
      ALU_CTL_SUB: result = a - b;
      ALU_CTL_AND: result = a & b;
      ALU_CTL_OR:  result = a | b;
      ALU_CTL_NOR: result = ~(a | b);
      ALU_CTL_SLT: result = W'($signed(a) < $signed(b));
      default:     result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/stage_ex.sv
// EX stage: ID/EX register, operand forwarding, ALU and branch-target adder,
// registered EX/MEM outputs.
module stage_ex
  import stage_ex_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  stage_ex_if.slave  bus
);

  id_ex_t       id_ex_q, id_ex_d;
  ex_mem_t      ex_mem_q, ex_mem_d;
  logic [W-1:0] fwd_a_c, fwd_b_c, alu_b_c, alu_result_c;
  logic         alu_zero_c;
  logic         ex_fwd_ok_c;
  alu_ctl_e     alu_ctl_c;

  // Next ID/EX contents; a flush turns the incoming instruction into a bubble.
  always_comb begin
    id_ex_d       = '0;
    id_ex_d.valid = bus.id_valid;
    id_ex_d.pc4   = bus.id_pc4;
    id_ex_d.rd1   = bus.id_rd1;
    id_ex_d.rd2   = bus.id_rd2;
    id_ex_d.imm   = bus.id_imm;
    id_ex_d.rs    = bus.id_rs;
    id_ex_d.rt    = bus.id_rt;
    id_ex_d.rd    = bus.id_rd;
    id_ex_d.ctrl  = ctrl_t'(bus.id_ctrl);
    if (bus.ex_flush) begin
      id_ex_d.valid = 1'b0;
      id_ex_d.ctrl  = '0;
    end
  end

  // Forwarding: EX/MEM (non-load) beats MEM/WB; register 0 never forwards.
  always_comb begin
    ex_fwd_ok_c = ex_mem_q.valid & ex_mem_q.reg_write & ~ex_mem_q.mem_read;

    fwd_a_c = id_ex_q.rd1;
    if (ex_fwd_ok_c && (ex_mem_q.write_reg == id_ex_q.rs) && (id_ex_q.rs != '0))
      fwd_a_c = ex_mem_q.alu_result;
    else if (bus.wb_reg_write && (bus.wb_write_reg == id_ex_q.rs) && (id_ex_q.rs != '0))
      fwd_a_c = bus.wb_data;

    fwd_b_c = id_ex_q.rd2;
    if (ex_fwd_ok_c && (ex_mem_q.write_reg == id_ex_q.rt) && (id_ex_q.rt != '0))
      fwd_b_c = ex_mem_q.alu_result;
    else if (bus.wb_reg_write && (bus.wb_write_reg == id_ex_q.rt) && (id_ex_q.rt != '0))
      fwd_b_c = bus.wb_data;

    alu_ctl_c = alu_decode(id_ex_q.ctrl.alu_op, id_ex_q.imm[FUNCT_W-1:0]);
    alu_b_c   = id_ex_q.ctrl.alu_src ? id_ex_q.imm : fwd_b_c;
  end

  ex_alu u_alu (
    .a       (fwd_a_c),
    .b       (alu_b_c),
    .alu_ctl (alu_ctl_c),
    .result  (alu_result_c),
    .zero    (alu_zero_c)
  );

  // Next EX/MEM contents; an invalid ID/EX entry produces no side effects downstream.
  always_comb begin
    ex_mem_d              = '0;
    ex_mem_d.valid        = id_ex_q.valid;
    ex_mem_d.alu_result   = alu_result_c;
    ex_mem_d.store_data   = fwd_b_c;
    ex_mem_d.write_reg    = id_ex_q.ctrl.reg_dst ? id_ex_q.rd : id_ex_q.rt;
    ex_mem_d.branch_pc    = id_ex_q.pc4 + {id_ex_q.imm[W-3:0], 2'b00};
    ex_mem_d.branch_taken = id_ex_q.valid & id_ex_q.ctrl.branch & alu_zero_c;
    ex_mem_d.mem_read     = id_ex_q.valid & id_ex_q.ctrl.mem_read;
    ex_mem_d.mem_write    = id_ex_q.valid & id_ex_q.ctrl.mem_write;
    ex_mem_d.reg_write    = id_ex_q.valid & id_ex_q.ctrl.reg_write &
                            (alu_ctl_c != ALU_CTL_NONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_q  <= '0;
      ex_mem_q <= '0;
    end else if (!bus.ex_stall) begin
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
    end
  end

  assign bus.ex_valid        = ex_mem_q.valid;
  assign bus.ex_alu_result   = ex_mem_q.alu_result;
  assign bus.ex_store_data   = ex_mem_q.store_data;
  assign bus.ex_write_reg    = ex_mem_q.write_reg;
  assign bus.ex_branch_pc    = ex_mem_q.branch_pc;
  assign bus.ex_branch_taken = ex_mem_q.branch_taken;
  assign bus.ex_mem_read     = ex_mem_q.mem_read;
  assign bus.ex_mem_write    = ex_mem_q.mem_write;
  assign bus.ex_reg_write    = ex_mem_q.reg_write;

endmodule

// File: tb/tb_stage_ex.sv
// Directed bench for stage_ex: reset, ALU ops, forwarding, branch, stall, flush.
module tb_stage_ex;

  localparam logic [7:0] C_R   = 8'hA1;
  localparam logic [7:0] C_LW  = 8'h45;
  localparam logic [7:0] C_SW  = 8'h42;
  localparam logic [7:0] C_BEQ = 8'h18;
  localparam logic [7:0] C_OP3 = 8'hB1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  stage_ex_if bus();

  stage_ex u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] pc4, input logic [31:0] rd1, input logic [31:0] rd2,
                       input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [7:0] ctrl);
    bus.id_valid = 1'b1;
    bus.id_pc4   = pc4;
    bus.id_rd1   = rd1;
    bus.id_rd2   = rd2;
    bus.id_imm   = imm;
    bus.id_rs    = rs;
    bus.id_rt    = rt;
    bus.id_rd    = rd;
    bus.id_ctrl  = ctrl;
  endtask

  task automatic idle();
    issue(32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 8'h00);
    bus.id_valid = 1'b0;
  endtask

  task automatic wb_set(input logic we, input logic [4:0] reg_idx, input logic [31:0] data);
    bus.wb_reg_write = we;
    bus.wb_write_reg = reg_idx;
    bus.wb_data      = data;
  endtask

  function automatic logic [105:0] ex_all();
    return {bus.ex_valid, bus.ex_alu_result, bus.ex_store_data, bus.ex_write_reg,
            bus.ex_branch_pc, bus.ex_branch_taken, bus.ex_mem_read, bus.ex_mem_write,
            bus.ex_reg_write};
  endfunction

  task automatic test_reset();
    issue(32'h44, 32'd5, 32'd7, 32'h20, 5'd8, 5'd9, 5'd10, C_R);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (ex_all() !== '0) begin n_err++; $display("FAIL reset_during[%0d]: got %h want 0", i, ex_all()); end
    end
    idle();
    rst = 1'b0;
    tick();
    n_cmp++; if (ex_all() !== '0) begin n_err++; $display("FAIL reset_after: got %h want 0", ex_all()); end
  endtask

  task automatic test_rtype();
    issue(32'h0, 32'd5, 32'd7, 32'h20, 5'd8, 5'd9, 5'd10, C_R);
    tick();
    issue(32'h0, 32'hFFFF_FFFF, 32'd1, 32'h2A, 5'd1, 5'd2, 5'd3, C_R);
    tick();
    n_cmp++; if (bus.ex_alu_result !== 32'd12) begin n_err++; $display("FAIL add_result: got %h want %h", bus.ex_alu_result, 32'd12); end
    n_cmp++; if (bus.ex_write_reg !== 5'd10) begin n_err++; $display("FAIL add_write_reg: got %0d want 10", bus.ex_write_reg); end
    n_cmp++; if ({bus.ex_valid, bus.ex_reg_write, bus.ex_store_data} !== {2'b11, 32'd7}) begin
      n_err++; $display("FAIL add_flags: got v=%b rw=%b sd=%h want v=1 rw=1 sd=7", bus.ex_valid, bus.ex_reg_write, bus.ex_store_data); end
    idle();
    tick();
    n_cmp++; if (bus.ex_alu_result !== 32'd1) begin n_err++; $display("FAIL slt_result: got %h want 1", bus.ex_alu_result); end
    n_cmp++; if (bus.ex_write_reg !== 5'd3) begin n_err++; $display("FAIL slt_write_reg: got %0d want 3", bus.ex_write_reg); end
  endtask

  task automatic test_alu_ops();
    logic [7:0]  ctl [8];
    logic [5:0]  fn  [8];
    logic [31:0] exp [8];
    logic        erw [8];
    ctl = '{C_R, C_R, C_R, C_R, C_R, C_R, C_R, C_OP3};
    fn  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h20};
    exp = '{32'h00E0_100E, 32'hE0FF_F1F0, 32'h00F0_000F, 32'hFFF0_0FFF,
            32'h000F_F000, 32'h0000_0001, 32'h0, 32'h0};
    erw = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      issue(32'h0, 32'hF0F0_00FF, 32'h0FF0_0F0F, {26'd0, fn[i]}, 5'd1, 5'd2, 5'd12, ctl[i]);
      tick();
      idle();
      tick();
      n_cmp++; if (bus.ex_alu_result !== exp[i]) begin n_err++; $display("FAIL alu_op[%0d]: got %h want %h", i, bus.ex_alu_result, exp[i]); end
      n_cmp++; if (bus.ex_reg_write !== erw[i]) begin n_err++; $display("FAIL alu_rw[%0d]: got %b want %b", i, bus.ex_reg_write, erw[i]); end
    end
  endtask

  task automatic test_back_to_back();
    // EX/MEM forward, with a conflicting MEM/WB value that must lose.
    issue(32'h0, 32'd5, 32'd7, 32'h20, 5'd8, 5'd9, 5'd10, C_R);
    tick();
    issue(32'h0, 32'd0, 32'd5, 32'h22, 5'd10, 5'd8, 5'd11, C_R);
    tick();
    wb_set(1'b1, 5'd10, 32'd99);
    idle();
    tick();
    n_cmp++; if (bus.ex_alu_result !== 32'd7) begin n_err++; $display("FAIL fwd_exmem: got %h want 7", bus.ex_alu_result); end
    n_cmp++; if ({bus.ex_write_reg, bus.ex_store_data} !== {5'd11, 32'd5}) begin
      n_err++; $display("FAIL fwd_exmem_wr_sd: got wr=%0d sd=%h want wr=11 sd=5", bus.ex_write_reg, bus.ex_store_data); end
    wb_set(1'b0, 5'd0, 32'd0);
    // One bubble between: MEM/WB forward.
    issue(32'h0, 32'd5, 32'd7, 32'h20, 5'd8, 5'd9, 5'd10, C_R);
    tick();
    idle();
    tick();
    issue(32'h0, 32'd0, 32'd5, 32'h22, 5'd10, 5'd8, 5'd11, C_R);
    tick();
    n_cmp++; if (bus.ex_valid !== 1'b0) begin n_err++; $display("FAIL bubble_valid: got %b want 0", bus.ex_valid); end
    wb_set(1'b1, 5'd10, 32'd12);
    idle();
    tick();
    n_cmp++; if (bus.ex_alu_result !== 32'd7) begin n_err++; $display("FAIL fwd_memwb: got %h want 7", bus.ex_alu_result); end
    // MEM/WB forward on operand B.
    wb_set(1'b1, 5'd6, 32'd40);
    issue(32'h0, 32'd2, 32'd0, 32'h20, 5'd1, 5'd6, 5'd7, C_R);
    tick();
    idle();
    tick();
    n_cmp++; if (bus.ex_alu_result !== 32'd42) begin n_err++; $display("FAIL fwd_memwb_b: got %h want 42", bus.ex_alu_result); end
    // Register 0 never forwards.
    wb_set(1'b1, 5'd0, 32'd99);
    issue(32'h0, 32'd3, 32'd4, 32'h20, 5'd0, 5'd0, 5'd13, C_R);
    tick();
    idle();
    tick();
    n_cmp++; if (bus.ex_alu_result !== 32'd7) begin n_err++; $display("FAIL fwd_r0: got %h want 7", bus.ex_alu_result); end
    wb_set(1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_branch();
    issue(32'h40, 32'd3, 32'd3, 32'h3, 5'd1, 5'd2, 5'd0, C_BEQ);
    tick();
    issue(32'h40, 32'd3, 32'd4, 32'h3, 5'd1, 5'd2, 5'd0, C_BEQ);
    tick();
    n_cmp++; if (bus.ex_branch_pc !== 32'h4C) begin n_err++; $display("FAIL beq_pc: got %h want 4c", bus.ex_branch_pc); end
    n_cmp++; if ({bus.ex_branch_taken, bus.ex_reg_write} !== 2'b10) begin
      n_err++; $display("FAIL beq_taken: got t=%b rw=%b want t=1 rw=0", bus.ex_branch_taken, bus.ex_reg_write); end
    idle();
    tick();
    n_cmp++; if ({bus.ex_branch_taken, bus.ex_branch_pc} !== {1'b0, 32'h4C}) begin
      n_err++; $display("FAIL bne_taken: got t=%b pc=%h want t=0 pc=4c", bus.ex_branch_taken, bus.ex_branch_pc); end
  endtask

  task automatic test_stall();
    issue(32'h0, 32'd5, 32'd7, 32'h20, 5'd8, 5'd9, 5'd10, C_R);
    tick();
    issue(32'h0, 32'h100, 32'd0, 32'd4, 5'd1, 5'd5, 5'd0, C_LW);
    tick();
    bus.ex_stall = 1'b1;
    issue(32'h0, 32'd100, 32'd200, 32'h20, 5'd2, 5'd3, 5'd20, C_R);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if ({bus.ex_valid, bus.ex_alu_result, bus.ex_write_reg} !== {1'b1, 32'd12, 5'd10}) begin
        n_err++; $display("FAIL stall_hold[%0d]: got v=%b r=%h wr=%0d want v=1 r=c wr=10", i, bus.ex_valid, bus.ex_alu_result, bus.ex_write_reg); end
    end
    bus.ex_stall = 1'b0;
    // Consumer of the load: must not take the load address from EX/MEM.
    issue(32'h0, 32'd1, 32'd2, 32'h20, 5'd5, 5'd0, 5'd6, C_R);
    tick();
    n_cmp++; if (bus.ex_alu_result !== 32'h104) begin n_err++; $display("FAIL lw_addr: got %h want 104", bus.ex_alu_result); end
    n_cmp++; if ({bus.ex_mem_read, bus.ex_reg_write, bus.ex_write_reg} !== {2'b11, 5'd5}) begin
      n_err++; $display("FAIL lw_ctrl: got mr=%b rw=%b wr=%0d want mr=1 rw=1 wr=5", bus.ex_mem_read, bus.ex_reg_write, bus.ex_write_reg); end
    idle();
    tick();
    n_cmp++; if (bus.ex_alu_result !== 32'd3) begin n_err++; $display("FAIL no_load_fwd: got %h want 3", bus.ex_alu_result); end
  endtask

  task automatic test_flush();
    issue(32'h0, 32'h200, 32'h55, 32'd8, 5'd1, 5'd2, 5'd0, C_SW);
    bus.ex_flush = 1'b1;
    tick();
    bus.ex_flush = 1'b0;
    idle();
    tick();
    n_cmp++; if ({bus.ex_valid, bus.ex_mem_write} !== 2'b00) begin
      n_err++; $display("FAIL flush_sw: got v=%b mw=%b want v=0 mw=0", bus.ex_valid, bus.ex_mem_write); end
    // Flush while stalled is ignored.
    issue(32'h0, 32'd5, 32'd7, 32'h20, 5'd8, 5'd9, 5'd10, C_R);
    tick();
    issue(32'h0, 32'h200, 32'h55, 32'd8, 5'd1, 5'd2, 5'd0, C_SW);
    bus.ex_stall = 1'b1;
    bus.ex_flush = 1'b1;
    tick();
    n_cmp++; if (bus.ex_valid !== 1'b0) begin n_err++; $display("FAIL flush_stall_hold: got %b want 0", bus.ex_valid); end
    bus.ex_stall = 1'b0;
    bus.ex_flush = 1'b0;
    idle();
    tick();
    n_cmp++; if ({bus.ex_valid, bus.ex_alu_result} !== {1'b1, 32'd12}) begin
      n_err++; $display("FAIL flush_stall_kept: got v=%b r=%h want v=1 r=c", bus.ex_valid, bus.ex_alu_result); end
    tick();
    n_cmp++; if ({bus.ex_valid, bus.ex_mem_write} !== 2'b00) begin
      n_err++; $display("FAIL flush_stall_sw_dropped: got v=%b mw=%b want 0 0", bus.ex_valid, bus.ex_mem_write); end
  endtask

  task automatic test_reset_mid_stall();
    issue(32'h0, 32'd5, 32'd7, 32'h20, 5'd8, 5'd9, 5'd10, C_R);
    tick();
    issue(32'h0, 32'd1, 32'd1, 32'h20, 5'd1, 5'd2, 5'd3, C_R);
    tick();
    bus.ex_stall = 1'b1;
    bus.ex_flush = 1'b1;
    rst = 1'b1;
    tick();
    n_cmp++; if (ex_all() !== '0) begin n_err++; $display("FAIL rst_mid_stall: got %h want 0", ex_all()); end
    rst = 1'b0;
    bus.ex_stall = 1'b0;
    bus.ex_flush = 1'b0;
    idle();
    tick();
    n_cmp++; if (ex_all() !== '0) begin n_err++; $display("FAIL rst_mid_stall_after: got %h want 0", ex_all()); end
  endtask

  initial begin
    bus.ex_stall = 1'b0;
    bus.ex_flush = 1'b0;
    wb_set(1'b0, 5'd0, 32'd0);
    idle();
    test_reset();
    test_rtype();
    test_alu_ops();
    test_back_to_back();
    test_branch();
    test_stall();
    test_flush();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
